// File: rtl/rom_read_arbiter.sv
// Two-port round-robin arbiter in front of a synchronous ROM with ROM_LAT cycles of read latency.
// One read is in flight at a time; the winning port gets a gnt pulse and later an rvalid pulse.
module rom_read_arbiter #(
    parameter int AW      = 4,
    parameter int DW      = 8,
    parameter int ROM_LAT = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req0,
    input  logic [AW-1:0] addr0,
    output logic          gnt0,
    output logic          rvalid0,
    output logic [DW-1:0] rdata0,
    input  logic          req1,
    input  logic [AW-1:0] addr1,
    output logic          gnt1,
    output logic          rvalid1,
    output logic [DW-1:0] rdata1,
    output logic          rom_read,
    output logic [AW-1:0] rom_addr,
    input  logic [DW-1:0] rom_data,
    output logic          busy,
    output logic [1:0]    state_dbg
);

    // Handshake: a requester holds reqN/addrN until it sees the one-cycle gntN pulse, then drops
    // reqN; requests are only sampled in IDLE. rvalidN pulses once with rdataN, which then holds.

    localparam int CW = (ROM_LAT > 1) ? $clog2(ROM_LAT) : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t        state;
    logic          sel;
    logic          last_grant;
    logic [CW-1:0] cnt;
    logic          win;

    // On a tie the port that did not win last time goes next.
    assign win       = (req0 && req1) ? ~last_grant : req1;
    assign state_dbg = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            sel        <= 1'b0;
            last_grant <= 1'b1;
            cnt        <= '0;
            gnt0       <= 1'b0;
            gnt1       <= 1'b0;
            rvalid0    <= 1'b0;
            rvalid1    <= 1'b0;
            rdata0     <= '0;
            rdata1     <= '0;
            rom_read   <= 1'b0;
            rom_addr   <= '0;
            busy       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req0 || req1) begin
                        state    <= ISSUE;
                        sel      <= win;
                        gnt0     <= ~win;
                        gnt1     <= win;
                        rom_read <= 1'b1;
                        rom_addr <= win ? addr1 : addr0;
                        busy     <= 1'b1;
                    end
                end
                ISSUE: begin
                    last_grant <= sel;
                    cnt        <= CW'(ROM_LAT - 1);
                    gnt0       <= 1'b0;
                    gnt1       <= 1'b0;
                    rom_read   <= 1'b0;
                    state      <= WAIT;
                end
                WAIT: begin
                    if (cnt == '0) begin
                        state <= RESP;
                        if (sel) begin
                            rdata1  <= rom_data;
                            rvalid1 <= 1'b1;
                        end else begin
                            rdata0  <= rom_data;
                            rvalid0 <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                RESP: begin
                    rvalid0 <= 1'b0;
                    rvalid1 <= 1'b0;
                    busy    <= 1'b0;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rom_read_arbiter.sv
// Bench for rom_read_arbiter: directed scenarios plus random traffic on a ROM_LAT=1 instance,
// checked each cycle by a transaction-level model, and a directed latency check at ROM_LAT=3.
module tb_rom_read_arbiter;

  localparam int LA = 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;

  // instance A, ROM_LAT=1
  logic       req0, req1;
  logic [3:0] addr0, addr1;
  logic       gnt0, gnt1, rvalid0, rvalid1, rom_read, busy;
  logic [7:0] rdata0, rdata1, rom_data;
  logic [3:0] rom_addr;
  logic [1:0] state_dbg;

  // instance B, ROM_LAT=3
  logic       req0b, req1b;
  logic [3:0] addr0b, addr1b;
  logic       gnt0b, gnt1b, rvalid0b, rvalid1b, rom_readb, busyb;
  logic [7:0] rdata0b, rdata1b, rom_datab;
  logic [3:0] rom_addrb;
  logic [1:0] state_dbgb;
  logic [3:0] pipe_b [3];

  rom_read_arbiter #(.AW(4), .DW(8), .ROM_LAT(1)) dut_a (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .addr0(addr0), .gnt0(gnt0), .rvalid0(rvalid0), .rdata0(rdata0),
    .req1(req1), .addr1(addr1), .gnt1(gnt1), .rvalid1(rvalid1), .rdata1(rdata1),
    .rom_read(rom_read), .rom_addr(rom_addr), .rom_data(rom_data),
    .busy(busy), .state_dbg(state_dbg)
  );

  rom_read_arbiter #(.AW(4), .DW(8), .ROM_LAT(3)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .req0(req0b), .addr0(addr0b), .gnt0(gnt0b), .rvalid0(rvalid0b), .rdata0(rdata0b),
    .req1(req1b), .addr1(addr1b), .gnt1(gnt1b), .rvalid1(rvalid1b), .rdata1(rdata1b),
    .rom_read(rom_readb), .rom_addr(rom_addrb), .rom_data(rom_datab),
    .busy(busyb), .state_dbg(state_dbgb)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ROM images word[i] = i; A answers one edge after a read, B three edges after
  initial rom_data = 8'h00;
  always @(posedge clk) if (rom_read) rom_data <= {4'h0, rom_addr};
  initial begin
    pipe_b[0] = 4'h0;
    pipe_b[1] = 4'h0;
    pipe_b[2] = 4'h0;
  end
  always @(posedge clk) begin
    pipe_b[0] <= rom_addrb;
    pipe_b[1] <= pipe_b[0];
    pipe_b[2] <= pipe_b[1];
  end
  assign rom_datab = {4'h0, pipe_b[2]};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // reference model for instance A: one transaction at a time, next IDLE 3+LA cycles after a sample
  int         next_free = 0;
  bit         pend = 0;
  int         pend_port = 0;
  logic [3:0] pend_addr = 4'h0;
  int         pend_g = 0;
  bit         m_last = 1'b1;
  logic [7:0] m_rd0 = 8'h00, m_rd1 = 8'h00;
  logic [3:0] m_addr = 4'h0;

  always @(negedge clk) begin
    bit e_g, e_rv, e_busy;
    if (!rst_n) begin
      next_free = 0; pend = 0; m_last = 1'b1;
      m_rd0 = 8'h00; m_rd1 = 8'h00; m_addr = 4'h0;
      chk("rst_gnt", {gnt1, gnt0}, 0);
      chk("rst_rvalid", {rvalid1, rvalid0}, 0);
      chk("rst_rom_read", rom_read, 0);
      chk("rst_busy", busy, 0);
      chk("rst_rdata", {rdata1, rdata0}, 0);
      chk("rst_rom_addr", rom_addr, 0);
    end else begin
      e_g    = pend && (cyc == pend_g);
      e_rv   = pend && (cyc == pend_g + 1 + LA);
      e_busy = pend && (cyc >= pend_g) && (cyc <= pend_g + 1 + LA);
      if (e_g) m_addr = pend_addr;
      if (e_rv && pend_port == 0) m_rd0 = {4'h0, pend_addr};
      if (e_rv && pend_port == 1) m_rd1 = {4'h0, pend_addr};
      chk("gnt0", gnt0, e_g && pend_port == 0);
      chk("gnt1", gnt1, e_g && pend_port == 1);
      chk("rvalid0", rvalid0, e_rv && pend_port == 0);
      chk("rvalid1", rvalid1, e_rv && pend_port == 1);
      chk("rom_read", rom_read, e_g);
      chk("rom_addr", rom_addr, m_addr);
      chk("busy", busy, e_busy);
      chk("rdata0", rdata0, m_rd0);
      chk("rdata1", rdata1, m_rd1);
      if (cyc >= next_free && (req0 || req1)) begin
        pend_port = (req0 && req1) ? int'(!m_last) : int'(req1);
        pend_addr = (pend_port == 1) ? addr1 : addr0;
        pend      = 1;
        pend_g    = cyc + 1;
        next_free = cyc + 3 + LA;
        m_last    = (pend_port == 1);
      end
    end
  end

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_gnt(output int port, output int at);
    port = -1;
    at = -1;
    for (int i = 0; i < 30; i++) begin
      step();
      if (gnt0 || gnt1) begin
        port = gnt1 ? 1 : 0;
        at = cyc;
        return;
      end
    end
    chk("gnt_timeout", 0, 1);
  endtask

  task automatic wait_rvalid1();
    for (int i = 0; i < 30; i++) begin
      step();
      if (rvalid1) return;
    end
    chk("rvalid1_timeout", 0, 1);
  endtask

  initial begin
    int port, at, g0, t0, seen;
    req0 = 0; req1 = 0; addr0 = 0; addr1 = 0;
    req0b = 0; req1b = 0; addr0b = 0; addr1b = 0;

    // tie from reset: port 0 first, then port 1, four cycles apart
    req0 = 1; addr0 = 4'd3; req1 = 1; addr1 = 4'd12;
    step(); step();
    rst_n = 1;
    wait_gnt(port, at);
    chk("tie_first", port, 0);
    g0 = at;
    req0 = 0;
    wait_gnt(port, at);
    chk("tie_second", port, 1);
    chk("tie_spacing", at - g0, 4);
    req1 = 0;
    repeat (4) step();
    chk("tie_rdata0", rdata0, 8'h03);
    chk("tie_rdata1", rdata1, 8'h0c);

    // fairness: both held for eight grants
    req0 = 1; req1 = 1;
    addr0 = 4'($urandom_range(0, 15)); addr1 = 4'($urandom_range(0, 15));
    for (int g = 0; g < 8; g++) begin
      wait_gnt(port, at);
      chk("fair_seq", port, g % 2);
    end
    req0 = 0; req1 = 0;
    repeat (6) step();

    // single read on port 0
    req0 = 1; addr0 = 4'd5; t0 = cyc;
    wait_gnt(port, at);
    chk("single_port", port, 0);
    chk("single_gnt_lat", at - t0, 1);
    chk("single_rom_addr", rom_addr, 5);
    req0 = 0;
    step(); step();
    chk("single_rvalid0", rvalid0, 1);
    chk("single_rdata0", rdata0, 8'h05);
    chk("single_rvalid1", rvalid1, 0);
    repeat (2) step();

    // sweep port 1 over the whole address space
    for (int i = 0; i < 16; i++) begin
      req1 = 1; addr1 = 4'(i);
      wait_gnt(port, at);
      chk("sweep_port", port, 1);
      req1 = 0;
      wait_rvalid1();
      chk("sweep_rdata1", rdata1, i);
    end
    repeat (3) step();
    chk("sweep_rom_addr_hold", rom_addr, 15);

    // a request withdrawn before IDLE samples it is never served
    req0 = 1; addr0 = 4'd7;
    wait_gnt(port, at);
    req0 = 0;
    step();
    req1 = 1; addr1 = 4'd2;
    step();
    req1 = 0;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (gnt1) seen++;
    end
    chk("dropped_req_gnt1", seen, 0);

    // reset in the middle of WAIT drops the read
    req0 = 1; addr0 = 4'd10;
    wait_gnt(port, at);
    req0 = 0;
    step();
    rst_n = 0;
    #1;
    chk("midrst_outputs", {gnt0, gnt1, rvalid0, rvalid1, rom_read, busy}, 0);
    chk("midrst_data", {rdata0, rdata1, rom_addr}, 0);
    step(); step();
    rst_n = 1;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (rvalid0 || busy) seen++;
    end
    chk("midrst_quiet", seen, 0);

    // random traffic; the model checks every cycle
    for (int c = 0; c < 400; c++) begin
      step();
      if (gnt0) req0 = 0;
      else if (!req0 && $urandom_range(0, 3) == 0) begin
        req0 = 1; addr0 = 4'($urandom_range(0, 15));
      end
      if (gnt1) req1 = 0;
      else if (!req1 && $urandom_range(0, 3) == 0) begin
        req1 = 1; addr1 = 4'($urandom_range(0, 15));
      end
    end
    for (int i = 0; i < 40 && (req0 || req1); i++) begin
      step();
      if (gnt0) req0 = 0;
      if (gnt1) req1 = 0;
    end
    chk("random_drain", {req0, req1}, 0);
    repeat (8) step();

    // ROM_LAT=3 instance: rvalid five cycles after the request is sampled
    req0b = 1; addr0b = 4'd9;
    for (int k = 1; k <= 6; k++) begin
      step();
      chk("lat3_gnt0", gnt0b, k == 1);
      chk("lat3_rom_read", rom_readb, k == 1);
      chk("lat3_rvalid0", rvalid0b, k == 5);
      chk("lat3_busy", busyb, k <= 5);
      chk("lat3_gnt1", {gnt1b, rvalid1b}, 0);
      if (k == 1) req0b = 0;
      if (k == 5) chk("lat3_rdata0", rdata0b, 8'h09);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
